// File: rtl/dlx_fetch_pkg.sv
// Shared types for the DLX instruction fetch requester.
// FSM states and the prefetch FIFO entry format.
package dlx_fetch_pkg;

  localparam int WORD_SIZE    = 32;
  localparam int ADDRESS_SIZE = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    GAP,
    HOLD,
    ERR
  } fetch_state_t;

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0]    instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO of fetch_entry_t.
// Flush empties it in one edge; head is zero while empty.
module fetch_fifo
  import dlx_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  fetch_entry_t r_mem [DEPTH];

  logic w_full;
  logic w_push;
  logic w_pop;

  assign count  = r_wr - r_rd;
  assign empty  = (r_wr == r_rd);
  assign w_full = (count == (AW+1)'(DEPTH));
  assign w_push = push && !w_full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push)
      r_mem[r_wr[AW-1:0]] <= push_entry;
  end

  assign head = empty ? '0 : r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/imem_fetch_requester.sv
// Instruction-memory read initiator: walks the PC, issues one
// read per word and queues returned words for the IF stage.
module imem_fetch_requester
  import dlx_fetch_pkg::*;
#(
  parameter int PC_INC     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDRESS_SIZE-1:0] boot_addr,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_SIZE-1:0] redirect_addr,
  output logic                    mem_ENABLE,
  output logic [ADDRESS_SIZE-1:0] mem_ADDRESS,
  input  logic [WORD_SIZE-1:0]    mem_DATA,
  input  logic                    mem_DATA_READY,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [WORD_SIZE-1:0]    instr_data,
  output logic [ADDRESS_SIZE-1:0] instr_pc,
  output logic                    fetch_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t            r_state;
  fetch_state_t            w_next;
  logic [ADDRESS_SIZE-1:0] r_pc;
  logic [ADDRESS_SIZE-1:0] w_pc_next;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_next;
  logic                    r_err;
  logic                    w_err_next;

  logic         w_en;
  logic         w_push;
  logic         w_flush;
  logic         w_pop;
  logic         w_empty;
  logic         w_free;
  logic [FW-1:0] w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_entry;

  assign w_free  = (w_count < FW'(FIFO_DEPTH));
  assign w_pop   = instr_valid && instr_ready;
  assign w_entry = '{pc: r_pc, instr: mem_DATA};

  always_comb begin
    w_next     = r_state;
    w_pc_next  = r_pc;
    w_cnt_next = r_cnt;
    w_err_next = r_err;
    w_en       = 1'b0;
    w_push     = 1'b0;
    w_flush    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_pc_next = boot_addr;
          w_next    = GAP;
        end
      end
      REQ: begin
        w_en       = 1'b1;
        w_cnt_next = '0;
        w_next     = WAIT;
      end
      WAIT: begin
        w_en = 1'b1;
        if (mem_DATA_READY) begin
          w_push    = 1'b1;
          w_pc_next = r_pc + ADDRESS_SIZE'(PC_INC);
          w_next    = GAP;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
          if (r_cnt == CW'(TIMEOUT - 1)) begin
            w_err_next = 1'b1;
            w_next     = ERR;
          end
        end
      end
      GAP:  w_next = w_free ? REQ : HOLD;
      HOLD: if (w_free) w_next = REQ;
      ERR:  w_next = ERR;
      default: w_next = IDLE;
    endcase
    // Redirect aborts any outstanding read and drops its data.
    if (redirect_valid && r_state != IDLE) begin
      w_flush    = 1'b1;
      w_push     = 1'b0;
      w_pc_next  = redirect_addr;
      w_err_next = 1'b0;
      w_next     = GAP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (w_flush),
    .push       (w_push),
    .push_entry (w_entry),
    .pop        (w_pop),
    .head       (w_head),
    .empty      (w_empty),
    .count      (w_count)
  );

  assign mem_ENABLE  = w_en;
  assign mem_ADDRESS = r_pc;
  assign instr_valid = !w_empty;
  assign instr_data  = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign fetch_err   = r_err;

endmodule

// File: tb/tb_imem_fetch_requester.sv
// Directed bench for imem_fetch_requester with a small ROM
// responder of programmable latency.
module tb_imem_fetch_requester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] boot_addr = 16'h0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_addr = 16'h0;
  logic        mem_ENABLE;
  logic [15:0] mem_ADDRESS;
  wire  [31:0] mem_DATA;
  logic        mem_DATA_READY;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [15:0] instr_pc;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  imem_fetch_requester dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .boot_addr      (boot_addr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .mem_ENABLE     (mem_ENABLE),
    .mem_ADDRESS    (mem_ADDRESS),
    .mem_DATA       (mem_DATA),
    .mem_DATA_READY (mem_DATA_READY),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [15:0] a);
    return {16'hC0DE, a ^ 16'h5A5A};
  endfunction

  // ROM: ready once ENABLE has been seen lat+1 edges in a row
  int lat = 1;
  int mute = 0;
  int rcnt = 0;
  always @(posedge clk) begin
    if (!mem_ENABLE) rcnt <= 0;
    else rcnt <= rcnt + 1;
  end
  assign mem_DATA_READY = (mute == 0) && (rcnt >= lat + 1);
  assign mem_DATA = mem_DATA_READY ? rom(mem_ADDRESS) : 32'hz;

  int          cyc = 0;
  int          n_req = 0;
  int          n_pop = 0;
  logic        prev_en = 1'b0;
  logic [15:0] req_addr [1024];
  int          req_cyc  [1024];
  logic [15:0] pop_pc   [1024];
  logic [31:0] pop_data [1024];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_en <= mem_ENABLE;
    if (mem_ENABLE && !prev_en && n_req < 1024) begin
      req_addr[n_req] <= mem_ADDRESS;
      req_cyc[n_req]  <= cyc;
      n_req <= n_req + 1;
    end
    if (instr_valid && instr_ready && n_pop < 1024) begin
      pop_pc[n_pop]   <= instr_pc;
      pop_data[n_pop] <= instr_data;
      n_pop <= n_pop + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    redirect_valid = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic kick(input logic [15:0] a);
    boot_addr = a;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (mem_ENABLE !== 1'b0) begin
      failures++; $display("FAIL reset_en got=%b exp=0", mem_ENABLE);
    end
    checks++;
    if (mem_ADDRESS !== 16'h0) begin
      failures++; $display("FAIL reset_addr got=%h exp=0", mem_ADDRESS);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid);
    end
    checks++;
    if (instr_data !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", instr_data);
    end
    checks++;
    if (instr_pc !== 16'h0) begin
      failures++; $display("FAIL reset_pc got=%h exp=0", instr_pc);
    end
    checks++;
    if (fetch_err !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b exp=0", fetch_err);
    end
  endtask

  task automatic test_boot;
    int b;
    int p;
    int i;
    do_reset();
    lat = 1; mute = 0; instr_ready = 1'b1;
    b = n_req; p = n_pop;
    kick(16'h0100);
    i = 0;
    while ((n_req < b + 3 || n_pop < p + 3) && i < 60) begin
      tick(1); i++;
    end
    checks++;
    if (i >= 60) begin
      failures++; $display("FAIL boot_wait got=%0d pops exp=3", n_pop - p);
      return;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_addr[b+k] !== 16'(16'h0100 + 4 * k)) begin
        failures++;
        $display("FAIL boot_req%0d got=%h exp=%h", k, req_addr[b+k],
                 16'(16'h0100 + 4 * k));
      end
      checks++;
      if (pop_pc[p+k] !== 16'(16'h0100 + 4 * k)) begin
        failures++;
        $display("FAIL boot_pc%0d got=%h exp=%h", k, pop_pc[p+k],
                 16'(16'h0100 + 4 * k));
      end
      checks++;
      if (pop_data[p+k] !== rom(16'(16'h0100 + 4 * k))) begin
        failures++;
        $display("FAIL boot_data%0d got=%h exp=%h", k, pop_data[p+k],
                 rom(16'(16'h0100 + 4 * k)));
      end
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (req_cyc[b+k] - req_cyc[b+k-1] != 4) begin
        failures++;
        $display("FAIL boot_gap%0d got=%0d exp=4", k,
                 req_cyc[b+k] - req_cyc[b+k-1]);
      end
    end
  endtask

  task automatic test_backpressure;
    int b;
    int p;
    do_reset();
    lat = 1; mute = 0; instr_ready = 1'b0;
    b = n_req; p = n_pop;
    kick(16'h0100);
    tick(40);
    checks++;
    if (n_req - b != 4) begin
      failures++; $display("FAIL bp_reqs got=%0d exp=4", n_req - b);
    end
    checks++;
    if (mem_ENABLE !== 1'b0) begin
      failures++; $display("FAIL bp_hold_en got=%b exp=0", mem_ENABLE);
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0100) begin
      failures++;
      $display("FAIL bp_head got=%b/%h exp=1/0100", instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    tick(20);
    checks++;
    if (n_pop - p != 1) begin
      failures++; $display("FAIL bp_pops got=%0d exp=1", n_pop - p);
    end
    checks++;
    if (n_req - b != 5 || req_addr[b+4] !== 16'h0110) begin
      failures++;
      $display("FAIL bp_refill got=%0d/%h exp=5/0110", n_req - b,
               req_addr[b+4]);
    end
    checks++;
    if (instr_pc !== 16'h0104 || instr_data !== rom(16'h0104)) begin
      failures++;
      $display("FAIL bp_newhead got=%h/%h exp=0104/%h", instr_pc,
               instr_data, rom(16'h0104));
    end
  endtask

  task automatic test_redirect;
    int b;
    int p;
    int i;
    do_reset();
    lat = 3; mute = 0; instr_ready = 1'b0;
    kick(16'h0100);
    i = 0;
    while (!(mem_ENABLE && mem_ADDRESS == 16'h0108 && mem_DATA_READY)
           && i < 100) begin
      tick(1); i++;
    end
    checks++;
    if (i >= 100) begin
      failures++; $display("FAIL redir_wait got=timeout exp=ready_on_0108");
      return;
    end
    redirect_addr = 16'h0200;
    redirect_valid = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_ENABLE !== 1'b0) begin
      failures++;
      $display("FAIL redir_flush got=%b/%b exp=0/0", instr_valid, mem_ENABLE);
    end
    b = n_req; p = n_pop;
    instr_ready = 1'b1;
    i = 0;
    while ((n_req <= b || n_pop <= p) && i < 40) begin
      tick(1); i++;
    end
    checks++;
    if (i >= 40) begin
      failures++; $display("FAIL redir_resume got=timeout exp=pop");
      return;
    end
    checks++;
    if (req_addr[b] !== 16'h0200) begin
      failures++; $display("FAIL redir_req got=%h exp=0200", req_addr[b]);
    end
    checks++;
    if (pop_pc[p] !== 16'h0200 || pop_data[p] !== rom(16'h0200)) begin
      failures++;
      $display("FAIL redir_pop got=%h/%h exp=0200/%h", pop_pc[p],
               pop_data[p], rom(16'h0200));
    end
  endtask

  task automatic test_timeout;
    int b;
    int p;
    int i;
    int en_cnt;
    do_reset();
    lat = 1; mute = 1; instr_ready = 1'b1;
    kick(16'h0040);
    en_cnt = 0;
    i = 0;
    while (i < 100) begin
      tick(1); i++;
      if (fetch_err) break;
      if (mem_ENABLE) en_cnt++;
    end
    checks++;
    if (fetch_err !== 1'b1 || mem_ENABLE !== 1'b0) begin
      failures++;
      $display("FAIL to_err got=%b/%b exp=1/0", fetch_err, mem_ENABLE);
    end
    checks++;
    if (en_cnt != 17) begin
      failures++; $display("FAIL to_cycles got=%0d exp=17", en_cnt);
    end
    tick(3);
    checks++;
    if (fetch_err !== 1'b1 || mem_ENABLE !== 1'b0) begin
      failures++;
      $display("FAIL to_sticky got=%b/%b exp=1/0", fetch_err, mem_ENABLE);
    end
    mute = 0;
    redirect_addr = 16'h0000;
    redirect_valid = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    checks++;
    if (fetch_err !== 1'b0) begin
      failures++; $display("FAIL to_clear got=%b exp=0", fetch_err);
    end
    b = n_req; p = n_pop;
    i = 0;
    while (n_pop <= p && i < 40) begin
      tick(1); i++;
    end
    checks++;
    if (i >= 40 || req_addr[b] !== 16'h0000 || pop_pc[p] !== 16'h0000) begin
      failures++;
      $display("FAIL to_resume got=%h/%h exp=0000/0000", req_addr[b],
               pop_pc[p]);
    end
  endtask

  task automatic test_wrap;
    int p;
    int i;
    do_reset();
    lat = 1; mute = 0; instr_ready = 1'b1;
    p = n_pop;
    kick(16'hFFFC);
    i = 0;
    while (n_pop < p + 2 && i < 40) begin
      tick(1); i++;
    end
    checks++;
    if (i >= 40) begin
      failures++; $display("FAIL wrap_wait got=%0d exp=2", n_pop - p);
      return;
    end
    checks++;
    if (pop_pc[p] !== 16'hFFFC || pop_data[p] !== rom(16'hFFFC)) begin
      failures++;
      $display("FAIL wrap_first got=%h/%h exp=FFFC/%h", pop_pc[p],
               pop_data[p], rom(16'hFFFC));
    end
    checks++;
    if (pop_pc[p+1] !== 16'h0000 || pop_data[p+1] !== rom(16'h0000)) begin
      failures++;
      $display("FAIL wrap_second got=%h/%h exp=0000/%h", pop_pc[p+1],
               pop_data[p+1], rom(16'h0000));
    end
    checks++;
    if (fetch_err !== 1'b0) begin
      failures++; $display("FAIL wrap_err got=%b exp=0", fetch_err);
    end
  endtask

  task automatic test_reset_mid;
    int i;
    do_reset();
    lat = 3; mute = 0; instr_ready = 1'b0;
    kick(16'h0100);
    i = 0;
    while (!(mem_ENABLE && mem_ADDRESS == 16'h010C) && i < 100) begin
      tick(1); i++;
    end
    tick(1);
    checks++;
    if (i >= 100 || instr_valid !== 1'b1 || mem_ENABLE !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre got=%b/%b exp=1/1", instr_valid, mem_ENABLE);
      return;
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (mem_ENABLE !== 1'b0 || mem_ADDRESS !== 16'h0 ||
        instr_valid !== 1'b0 || instr_data !== 32'h0 ||
        instr_pc !== 16'h0 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL rmid_out got=%b/%h/%b/%h/%h/%b exp=0/0/0/0/0/0",
               mem_ENABLE, mem_ADDRESS, instr_valid, instr_data,
               instr_pc, fetch_err);
    end
    rst = 1'b0;
  endtask

  initial begin
    tick(1);
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
